ekf_soc_top: RTL and testbench

- Top of the battery state-of-charge (SOC) estimator: a periodic prediction engine for an RC-equivalent battery model plus a two-digit seven-segment SOC display.
- On a start command it advances the model one step every STEP_CYCLES clocks, using a fixed load current and a direction selected by mode.
- Outputs are the SOC estimate, the RC-branch voltage estimate, a per-step done strobe and display segments.
- Directly instantiated by the board wrapper and the system bench.

---
 rtl/ekf_soc_top_if.sv | 21 ++
 rtl/ekf_soc_top.sv | 152 +++++++++++++++
 tb/tb_ekf_soc_top.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/ekf_soc_top_if.sv
// Control/status bundle for the SOC estimator: run/abort requests in, estimates and display out.
interface ekf_soc_top_if;
    logic        start;
    logic        mode;
    logic        stop_top;
    logic [23:0] ekf_vrc;
    logic [23:0] ekf_soc;
    logic        ekf_done;
    logic [6:0]  fnd_out_1;
    logic [6:0]  fnd_out_10;

    modport master (
        output start, mode, stop_top,
        input  ekf_vrc, ekf_soc, ekf_done, fnd_out_1, fnd_out_10
    );

    modport slave (
        input  start, mode, stop_top,
        output ekf_vrc, ekf_soc, ekf_done, fnd_out_1, fnd_out_10
    );
endinterface

// File: rtl/ekf_soc_top.sv
// Battery SOC estimator: periodic RC-model prediction step plus two-digit SOC display.
// Define FND_EN to build the seven-segment decoder; otherwise segments are tied off (all dark).
module ekf_soc_top #(
    parameter int          STEP_CYCLES = 1000,
    parameter logic [4:0]  I_B         = 5'd10,
    parameter logic [23:0] R1_GAIN     = 24'h000666,
    parameter int          TAU_SHIFT   = 4,
    parameter logic [23:0] DSOC_PER_A  = 24'h000008,
    parameter logic [23:0] SOC_INIT    = 24'h800000
) (
    input  logic          clk,
    input  logic          n_rst,
    ekf_soc_top_if.slave  bus
);

    localparam int          CW       = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CW-1:0] LAST   = CW'(STEP_CYCLES - 1);
    localparam logic [23:0] SOC_FULL = 24'h800000;
    localparam logic [28:0] TGT_P    = 29'(I_B) * 29'(R1_GAIN);
    localparam logic [23:0] TGT      = TGT_P[23:0];
    localparam logic [29:0] D_SOC    = 30'(I_B) * 30'(DSOC_PER_A);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_UPDATE} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          mode_r;
    logic          upd;
    logic [23:0]   soc_q, soc_nxt;
    logic [23:0]   vrc_q, vrc_nxt;
    logic          done_q;
    logic          sat;

    logic [23:0]        target;
    logic signed [24:0] diff, stp, sum;
    logic [29:0]        soc_ext, soc_add;

    // RC branch relaxes toward its steady-state voltage by 1/2^TAU_SHIFT per step
    always_comb begin
        target  = mode_r ? (24'd0 - TGT) : TGT;
        diff    = $signed({target[23], target}) - $signed({vrc_q[23], vrc_q});
        stp     = diff >>> TAU_SHIFT;
        sum     = $signed({vrc_q[23], vrc_q}) + stp;
        vrc_nxt = sum[23:0];
    end

    // Wide intermediates so neither direction can wrap before clamping
    always_comb begin
        soc_ext = {6'd0, soc_q};
        soc_add = soc_ext + D_SOC;
        if (mode_r) begin
            soc_nxt = (soc_add >= {6'd0, SOC_FULL}) ? SOC_FULL : soc_add[23:0];
            sat     = (soc_nxt == SOC_FULL);
        end else begin
            soc_nxt = (soc_ext <= D_SOC) ? 24'd0 : soc_q - D_SOC[23:0];
            sat     = (soc_nxt == 24'd0);
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        upd     = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start && !bus.stop_top) begin
                    state_n = S_WAIT;
                    cnt_n   = '0;
                end
            end
            S_WAIT: begin
                if (bus.stop_top)     state_n = S_IDLE;
                else if (cnt == LAST) state_n = S_UPDATE;
                else                  cnt_n   = cnt + 1'b1;
            end
            S_UPDATE: begin
                if (bus.stop_top) begin
                    state_n = S_IDLE;
                end else begin
                    upd     = 1'b1;
                    cnt_n   = '0;
                    state_n = sat ? S_IDLE : S_WAIT;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            mode_r <= 1'b0;
            soc_q  <= SOC_INIT;
            vrc_q  <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            done_q <= upd;
            if (state == S_IDLE && bus.start && !bus.stop_top)
                mode_r <= bus.mode;
            if (upd) begin
                soc_q <= soc_nxt;
                vrc_q <= vrc_nxt;
            end
        end
    end

    assign bus.ekf_soc  = soc_q;
    assign bus.ekf_vrc  = vrc_q;
    assign bus.ekf_done = done_q;

`ifdef FND_EN
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    logic [30:0] pct_prod;
    logic [7:0]  pct_raw;
    logic [6:0]  pct;
    logic [3:0]  tens, ones;

    // 100 % would need three digits, so the display tops out at 99
    always_comb begin
        pct_prod = 31'(soc_q) * 31'd100;
        pct_raw  = pct_prod[30:23];
        pct      = (pct_raw > 8'd99) ? 7'd99 : pct_raw[6:0];
        tens     = 4'(pct / 7'd10);
        ones     = 4'(pct % 7'd10);
    end

    assign bus.fnd_out_10 = seg7(tens);
    assign bus.fnd_out_1  = seg7(ones);
`else
    assign bus.fnd_out_10 = 7'h7F;
    assign bus.fnd_out_1  = 7'h7F;
`endif

endmodule

// File: tb/tb_ekf_soc_top.sv
// Directed bench for ekf_soc_top: step timing, stop/resume, charge saturation, low-SOC floor.
module tb_ekf_soc_top;

    logic clk = 1'b0;
    logic n_rst;
    int   n_cmp = 0;
    int   n_bad = 0;

`ifdef FND_EN
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_0 = 7'b1000000;
`else
    localparam logic [6:0] SEG_9 = 7'h7F;
    localparam logic [6:0] SEG_0 = 7'h7F;
`endif

    ekf_soc_top_if if_a ();
    ekf_soc_top_if if_b ();

    ekf_soc_top dut_a (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (if_a)
    );

    ekf_soc_top #(.SOC_INIT(24'h000060)) dut_b (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (if_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic done_of(input bit b);
        return b ? if_b.ekf_done : if_a.ekf_done;
    endfunction

    function automatic logic [23:0] soc_of(input bit b);
        return b ? if_b.ekf_soc : if_a.ekf_soc;
    endfunction

    function automatic logic [23:0] vrc_of(input bit b);
        return b ? if_b.ekf_vrc : if_a.ekf_vrc;
    endfunction

    task automatic drive(input bit b, input logic s, input logic m, input logic st);
        if (b) begin if_b.start = s; if_b.mode = m; if_b.stop_top = st; end
        else   begin if_a.start = s; if_a.mode = m; if_a.stop_top = st; end
    endtask

    // One-cycle request; returns #1 after the sampling edge
    task automatic pulse(input bit b, input logic s, input logic m, input logic st);
        @(negedge clk);
        drive(b, s, m, st);
        @(posedge clk);
        #1;
        drive(b, 1'b0, m, 1'b0);
    endtask

    task automatic wait_done(input bit b, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!done_of(b) && n < 3000);
    endtask

    task automatic count_done(input bit b, input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (done_of(b)) n++;
        end
    endtask

    task automatic step_chk(input bit b, input string tag, input logic [23:0] soc_e,
                            input logic [23:0] vrc_e);
        int n;
        wait_done(b, n);
        chk({tag, "_lat"}, n, 1001);
        chk({tag, "_soc"}, soc_of(b), soc_e);
        chk({tag, "_vrc"}, vrc_of(b), vrc_e);
    endtask

    initial begin
        int n;
        n_rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_soc", if_a.ekf_soc, 24'h800000);
        chk("rst_vrc", if_a.ekf_vrc, 24'h0);
        chk("rst_done", if_a.ekf_done, 1'b0);
        chk("rst_fnd10", if_a.fnd_out_10, SEG_9);
        chk("rst_fnd1", if_a.fnd_out_1, SEG_9);
        chk("rst_soc_b", if_b.ekf_soc, 24'h000060);
        n_rst = 1'b1;

        // start and stop together from IDLE: stop wins
        pulse(1'b0, 1'b1, 1'b0, 1'b1);
        count_done(1'b0, 1100, n);
        chk("startstop_done", n, 0);
        chk("startstop_soc", if_a.ekf_soc, 24'h800000);

        // discharge: target +0x3FFC, 0x50 per step
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        step_chk(1'b0, "dis1", 24'h7FFFB0, 24'h0003FF);
        @(posedge clk);
        #1;
        chk("done_1cyc", if_a.ekf_done, 1'b0);
        wait_done(1'b0, n);
        chk("dis2_lat", n, 1000);
        chk("dis2_soc", if_a.ekf_soc, 24'h7FFF60);
        chk("dis2_vrc", if_a.ekf_vrc, 24'h0007BE);

        // abort mid-wait, idle, then resume from held values
        repeat (500) @(posedge clk);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        count_done(1'b0, 1000, n);
        chk("stop_done", n, 0);
        chk("stop_soc", if_a.ekf_soc, 24'h7FFF60);
        chk("stop_vrc", if_a.ekf_vrc, 24'h0007BE);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        step_chk(1'b0, "dis3", 24'h7FFF10, 24'h000B41);

        // charge back up to full; target -0x3FFC
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        pulse(1'b0, 1'b1, 1'b1, 1'b0);
        step_chk(1'b0, "chg1", 24'h7FFF60, 24'h00068D);
        step_chk(1'b0, "chg2", 24'h7FFFB0, 24'h000224);
        step_chk(1'b0, "chg3", 24'h800000, 24'hFFFE02);
        count_done(1'b0, 1100, n);
        chk("chg_sat_idle", n, 0);

        // start again at the limit: one step, soc held, back to IDLE
        pulse(1'b0, 1'b1, 1'b1, 1'b0);
        step_chk(1'b0, "chg4", 24'h800000, 24'hFFFA22);
        count_done(1'b0, 1100, n);
        chk("chg4_idle", n, 0);

        // low-SOC instance: floor at zero then IDLE
        pulse(1'b1, 1'b1, 1'b0, 1'b0);
        step_chk(1'b1, "low1", 24'h000010, 24'h0003FF);
        step_chk(1'b1, "low2", 24'h000000, 24'h0007BE);
        count_done(1'b1, 1100, n);
        chk("low_idle", n, 0);
        chk("low_fnd10", if_b.fnd_out_10, SEG_0);
        chk("low_fnd1", if_b.fnd_out_1, SEG_0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
